timer_dev: RTL and testbench
============================

// Module: timer_dev
// PURPOSE
//  Programmable countdown timer; the device-side responder on the bridge's DEVn port.
//  Bridge drives the address, write data and per-device write enable; the timer returns
//  read data combinationally and raises IRQ toward the CPU's interrupt logic.
//  Occupies one 16-byte window. Registers are selected by DEV_Addr[3:2].
// PARAMETERS
//  DW   32  data/register width (PRESET, COUNT, DEV_WD, DEV_RD)
// PORTS
//  clk      in   1    system clock; all state changes on rising edge
//  reset    in   1    asynchronous, active-low reset (0 = reset)
//  DEV_Addr in   32   byte address from bridge; only [3:2] decoded
//  DEV_WD   in   DW   write data from bridge
//  WeDEV    in   1    write enable for this device (bridge already qualified hit)
//  DEV_RD   out  DW   read data, combinational from DEV_Addr[3:2]
//  IRQ      out  1    interrupt request = CTRL.IM & irq_flag
// BEHAVIOUR
//  Registers: [3:2]=0 CTRL (bit0 EN, bits2:1 MODE, bit3 IM, rest read 0); 1 PRESET;
//   2 COUNT (read-only, writes ignored); 3 reserved (reads 0, writes ignored).
//  Reset (reset==0, async): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE; IRQ=0.
//  Writes: when WeDEV=1 at clk edge, CTRL<=DEV_WD[3:0] or PRESET<=DEV_WD. Write to CTRL
//   or PRESET also clears irq_flag. PRESET write never alters COUNT until next LOAD.
//  MODE: 00 one-shot; 01 auto-reload; 10/11 behave as 00.
//  FSM (one transition per edge):
//   IDLE: EN=1 -> LOAD; else stay, COUNT held.
//   LOAD: COUNT<=PRESET -> CNT (EN=0 here -> IDLE, COUNT still loaded).
//   CNT : EN=0 -> IDLE, COUNT frozen; COUNT>1 -> COUNT-1, stay;
//         COUNT<=1 -> COUNT<=0, irq_flag<=1 -> INT.
//   INT : one-shot: CTRL.EN<=0 -> IDLE, irq_flag held until CTRL/PRESET write.
//         auto-reload: irq_flag<=0 -> LOAD (flag, hence IRQ, is a 1-cycle pulse).
//  Latency: CTRL.EN written at edge e0, PRESET=N>=1: LOAD at e1, COUNT=N at e2,
//   COUNT=N-k at e2+k, INT/irq_flag at e(N+2). PRESET=0 behaves as PRESET=1.
//  Auto-reload period: N+2 cycles between IRQ pulses.
//  Simultaneous events: software CTRL write in the same edge as INT's EN clear wins
//   (written value taken); CTRL/PRESET write in same edge as irq_flag set -> flag set
//   (set beats clear). Re-enable while in INT handled next edge from IDLE/LOAD.
//  Clearing EN mid-count freezes COUNT; re-enabling restarts via LOAD from PRESET.
//  IM=0 masks IRQ only; irq_flag still tracks.
//  Reset asserted mid-count: immediate return to reset values, IRQ drops asynchronously.
//  DEV_RD independent of WeDEV; read during write returns pre-edge value.
// TESTING
//  1 Reset: reset=0 mid-count -> all reads 0, IRQ=0 same cycle; state IDLE after release.
//  2 One-shot: PRESET=5, CTRL=0x9 -> IRQ rises at 7th edge after CTRL write; COUNT=0,
//    CTRL reads 0x8; IRQ stays high until PRESET write clears it.
//  3 Auto-reload: PRESET=3, CTRL=0xB -> 1-cycle IRQ pulses every 5 cycles, COUNT 3,2,1,0.
//  4 Pause: PRESET=10, CTRL=0x9, clear EN when COUNT=6 -> COUNT holds 6; re-set EN ->
//    COUNT reloads 10 two edges later, IRQ 12 edges after re-enable.
//  5 Mask/ignored writes: CTRL=0x1, PRESET=2 -> irq_flag set but IRQ=0; write COUNT=0x55
//    and addr 0xC -> COUNT unaffected, reg 3 reads 0.
//  6 PRESET=0, CTRL=0x9 -> IRQ at 3rd edge after write (same as PRESET=1).

Source files
------------

// File: rtl/timer_dev.sv
// Programmable countdown timer on a 16-byte bus window; registers CTRL/PRESET/COUNT/reserved.
// Reads are combinational from DEV_Addr[3:2]; IRQ = CTRL.IM & irqFlag.
module timer_dev #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   DEV_Addr,
  input  logic [DW-1:0] DEV_WD,
  input  logic          WeDEV,
  output logic [DW-1:0] DEV_RD,
  output logic          IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} stateT;

  stateT         state, stateNxt;
  logic [3:0]    ctrl, ctrlNxt;
  logic [DW-1:0] preset, presetNxt;
  logic [DW-1:0] count, countNxt;
  logic          irqFlag, irqFlagNxt;
  logic          flagSet, flagClr, enClr;
  logic [1:0]    regSel;
  logic          unusedAddr;

  assign regSel     = DEV_Addr[3:2];
  assign unusedAddr = ^{DEV_Addr[31:4], DEV_Addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ctrl    <= 4'h0;
      preset  <= '0;
      count   <= '0;
      irqFlag <= 1'b0;
    end else begin
      state   <= stateNxt;
      ctrl    <= ctrlNxt;
      preset  <= presetNxt;
      count   <= countNxt;
      irqFlag <= irqFlagNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    ctrlNxt    = ctrl;
    presetNxt  = preset;
    countNxt   = count;
    irqFlagNxt = irqFlag;
    flagSet    = 1'b0;
    flagClr    = 1'b0;
    enClr      = 1'b0;

    case (state)
      IDLE: begin
        if (ctrl[0]) stateNxt = LOAD;
      end
      LOAD: begin
        countNxt = preset;
        stateNxt = ctrl[0] ? CNT : IDLE;
      end
      CNT: begin
        if (!ctrl[0]) begin
          stateNxt = IDLE;
        end else if (count > DW'(1)) begin
          countNxt = count - DW'(1);
        end else begin
          // PRESET of 0 lands here too, so it behaves like PRESET of 1
          countNxt = '0;
          flagSet  = 1'b1;
          stateNxt = INT;
        end
      end
      INT: begin
        if (ctrl[2:1] == 2'b01) begin
          flagClr  = 1'b1;
          stateNxt = LOAD;
        end else begin
          enClr    = 1'b1;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase

    if (enClr) ctrlNxt[0] = 1'b0;

    // Software write overrides the one-shot EN clear of the same edge
    if (WeDEV) begin
      case (regSel)
        2'd0: begin
          ctrlNxt = DEV_WD[3:0];
          flagClr = 1'b1;
        end
        2'd1: begin
          presetNxt = DEV_WD;
          flagClr   = 1'b1;
        end
        default: ;
      endcase
    end

    if (flagSet)      irqFlagNxt = 1'b1;
    else if (flagClr) irqFlagNxt = 1'b0;
  end

  always_comb begin
    DEV_RD = '0;
    case (regSel)
      2'd0:    DEV_RD = {{(DW-4){1'b0}}, ctrl};
      2'd1:    DEV_RD = preset;
      2'd2:    DEV_RD = count;
      default: DEV_RD = '0;
    endcase
  end

  assign IRQ = ctrl[3] & irqFlag;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: one-shot, auto-reload, pause, mask, reset and same-edge cases.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [31:0] DEV_Addr;
  logic [31:0] DEV_WD;
  logic        WeDEV;
  logic [31:0] DEV_RD;
  logic        IRQ;

  int numChecks = 0;
  int numFails  = 0;

  timer_dev #(.DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .DEV_Addr (DEV_Addr),
    .DEV_WD   (DEV_WD),
    .WeDEV    (WeDEV),
    .DEV_RD   (DEV_RD),
    .IRQ      (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    DEV_Addr = addr;
    DEV_WD   = data;
    WeDEV    = 1'b1;
    @(posedge clk);
    #1;
    WeDEV    = 1'b0;
  endtask

  task automatic rdChk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    DEV_Addr = addr;
    #1;
    check(tag, DEV_RD, exp);
  endtask

  int osCnt[7] = '{0, 5, 4, 3, 2, 1, 0};
  int osIrq[7] = '{0, 0, 0, 0, 0, 0, 1};
  int arCnt[11] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
  int arIrq[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

  initial begin
    reset    = 1'b0;
    DEV_Addr = 32'h0;
    DEV_WD   = 32'h0;
    WeDEV    = 1'b0;
    tick();
    tick();
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    rdChk("rst_ctrl", 32'h0, 32'h0);
    rdChk("rst_preset", 32'h4, 32'h0);
    rdChk("rst_count", 32'h8, 32'h0);
    reset = 1'b1;
    tick();

    // one-shot, PRESET=5, IM=1
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    for (int k = 0; k < 7; k++) begin
      tick();
      rdChk($sformatf("os_cnt%0d", k + 1), 32'h8, 32'(osCnt[k]));
      check($sformatf("os_irq%0d", k + 1), {31'h0, IRQ}, 32'(osIrq[k]));
    end
    tick();
    rdChk("os_ctrl", 32'h0, 32'h8);
    tick();
    tick();
    check("os_irq_hold", {31'h0, IRQ}, 32'h1);
    wr(32'h4, 32'd7);
    check("os_irq_clr", {31'h0, IRQ}, 32'h0);
    rdChk("os_cnt_keep", 32'h8, 32'h0);

    // auto-reload, PRESET=3
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int k = 0; k < 11; k++) begin
      tick();
      rdChk($sformatf("ar_cnt%0d", k + 1), 32'h8, 32'(arCnt[k]));
      check($sformatf("ar_irq%0d", k + 1), {31'h0, IRQ}, 32'(arIrq[k]));
    end
    for (int k = 0; k < 4; k++) tick();
    check("ar_irq15", {31'h0, IRQ}, 32'h1);

    // async reset while IRQ is high
    reset = 1'b0;
    #1;
    check("mid_rst_irq", {31'h0, IRQ}, 32'h0);
    rdChk("mid_rst_ctrl", 32'h0, 32'h0);
    rdChk("mid_rst_preset", 32'h4, 32'h0);
    rdChk("mid_rst_count", 32'h8, 32'h0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rdChk("post_rst_ctrl", 32'h0, 32'h0);
    rdChk("post_rst_count", 32'h8, 32'h0);
    check("post_rst_irq", {31'h0, IRQ}, 32'h0);

    // pause / resume, PRESET=10
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    for (int k = 0; k < 5; k++) tick();
    rdChk("pz_cnt7", 32'h8, 32'd7);
    wr(32'h0, 32'h8);
    rdChk("pz_cnt6", 32'h8, 32'd6);
    for (int k = 0; k < 3; k++) tick();
    rdChk("pz_hold", 32'h8, 32'd6);
    check("pz_irq", {31'h0, IRQ}, 32'h0);
    wr(32'h0, 32'h9);
    tick();
    rdChk("rs_load", 32'h8, 32'd6);
    tick();
    rdChk("rs_cnt10", 32'h8, 32'd10);
    for (int k = 0; k < 9; k++) tick();
    rdChk("rs_cnt1", 32'h8, 32'd1);
    check("rs_irq11", {31'h0, IRQ}, 32'h0);
    tick();
    check("rs_irq12", {31'h0, IRQ}, 32'h1);

    // masked interrupt and ignored writes
    wr(32'h4, 32'd2);
    check("mk_clr", {31'h0, IRQ}, 32'h0);
    wr(32'h0, 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("mk_irq%0d", k + 1), {31'h0, IRQ}, 32'h0);
    end
    rdChk("mk_cnt", 32'h8, 32'h0);
    rdChk("mk_ctrl", 32'h0, 32'h0);
    wr(32'h8, 32'h55);
    rdChk("ro_count", 32'h8, 32'h0);
    wr(32'hC, 32'h55);
    rdChk("rsv_read", 32'hC, 32'h0);
    rdChk("rsv_preset", 32'h4, 32'd2);
    rdChk("rsv_ctrl", 32'h0, 32'h0);

    // PRESET=0 behaves like PRESET=1
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    tick();
    tick();
    check("p0_irq2", {31'h0, IRQ}, 32'h0);
    tick();
    check("p0_irq3", {31'h0, IRQ}, 32'h1);

    // same-edge: flag set beats PRESET-write clear; CTRL write beats EN clear
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h9);
    for (int k = 0; k < 3; k++) tick();
    rdChk("se_cnt1", 32'h8, 32'd1);
    wr(32'h4, 32'd2);
    check("se_set_wins", {31'h0, IRQ}, 32'h1);
    wr(32'h0, 32'hB);
    rdChk("se_ctrl_wins", 32'h0, 32'hB);
    check("se_irq_clr", {31'h0, IRQ}, 32'h0);
    tick();
    tick();
    rdChk("se_reload", 32'h8, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
